// File: rtl/snowv_lane_modadd_if.sv
// snowv_lane_modadd_if: valid/ready operand and result bus for snowv_lane_modadd.
//   master : drives in_valid/in_a/in_b/in_sub/in_half and out_ready,
//            observes in_ready/out_valid/out_sum (and out_carry).
//   slave  : the adder side of the same signals.
// Optional feature macro: SNOWV_MODADD_CARRY_EN adds out_carry[2*LANES-1:0].
`timescale 1ns/1ps
interface snowv_lane_modadd_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32
);
    localparam int W = LANES * LANE_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_sub;
    logic             in_half;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
`ifdef SNOWV_MODADD_CARRY_EN
    logic [2*LANES-1:0] out_carry;

    modport master (output in_valid, in_a, in_b, in_sub, in_half, out_ready,
                    input  in_ready, out_valid, out_sum, out_carry);
    modport slave  (input  in_valid, in_a, in_b, in_sub, in_half, out_ready,
                    output in_ready, out_valid, out_sum, out_carry);
`else
    modport master (output in_valid, in_a, in_b, in_sub, in_half, out_ready,
                    input  in_ready, out_valid, out_sum);
    modport slave  (input  in_valid, in_a, in_b, in_sub, in_half, out_ready,
                    output in_ready, out_valid, out_sum);
`endif
endinterface

// File: rtl/snowv_lane_modadd.sv
// snowv_lane_modadd: pipelined multi-lane modular add/sub for the SNOW-V datapath.
// Each LANE_W lane computes (a +/- b) mod 2^LANE_W, or in half mode each
// LANE_W/2 sub-lane independently. PIPE_STAGES = 1 or 2 register stages.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - snowv_lane_modadd_if.slave (in_* operand beat, out_* result beat)
// Optional feature macro: SNOWV_MODADD_CARRY_EN (per-sub-lane carry/borrow flags).
`timescale 1ns/1ps

// One LANE_W/2 slice: a + (sub ? ~b : b) + cin.
module snowv_modadd_half #(
    parameter int H = 16
) (
    input  logic [H-1:0] a,
    input  logic [H-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [H-1:0] s,
    output logic         cout
);
    logic [H:0] t;
    assign t = {1'b0, a} + {1'b0, b ^ {H{sub}}} + {{H{1'b0}}, cin};
    assign {cout, s} = t;
endmodule

module snowv_lane_modadd #(
    parameter int LANES       = 4,
    parameter int LANE_W      = 32,
    parameter int PIPE_STAGES = 1
) (
    input logic               clk,
    input logic               rst,
    snowv_lane_modadd_if.slave bus
);
    localparam int H = LANE_W / 2;
    localparam int W = LANES * LANE_W;

    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe
        $error("snowv_lane_modadd: PIPE_STAGES must be 1 or 2");
    end
    if (LANE_W < 4 || (LANE_W % 2) != 0) begin : g_bad_lane
        $error("snowv_lane_modadd: LANE_W must be even and >= 4");
    end

    // low half always comes straight from the inputs; high half from either
    // the inputs (1 stage) or the stage-1 registers (2 stages)
    logic [LANES-1:0][H-1:0] lo_s, hi_a, hi_b, hi_s, hi_lo;
    logic [LANES-1:0]        lo_c, hi_cin, hi_c, hi_clo;
    logic                    hi_sub, hi_half;
    logic [W-1:0]            res_sum;
    logic [W-1:0]            sum_q;
    logic [PIPE_STAGES:1]    vld_pipe;
`ifdef SNOWV_MODADD_CARRY_EN
    logic [2*LANES-1:0]      res_carry;
    logic [2*LANES-1:0]      carry_q;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        snowv_modadd_half #(.H(H)) u_lo (
            .a(bus.in_a[i*LANE_W +: H]), .b(bus.in_b[i*LANE_W +: H]),
            .sub(bus.in_sub), .cin(bus.in_sub), .s(lo_s[i]), .cout(lo_c[i]));
        snowv_modadd_half #(.H(H)) u_hi (
            .a(hi_a[i]), .b(hi_b[i]),
            .sub(hi_sub), .cin(hi_cin[i]), .s(hi_s[i]), .cout(hi_c[i]));
        assign res_sum[i*LANE_W +: LANE_W] = {hi_s[i], hi_lo[i]};
`ifdef SNOWV_MODADD_CARRY_EN
        // borrow = !carry-out when subtracting; low flag only meaningful in half mode
        assign res_carry[2*i+1] = hi_c[i] ^ hi_sub;
        assign res_carry[2*i]   = hi_half & (hi_clo[i] ^ hi_sub);
`endif
    end

`ifndef SNOWV_MODADD_CARRY_EN
    logic unused_flags;
    assign unused_flags = ^{hi_c, hi_clo, hi_half};
`endif

    if (PIPE_STAGES == 1) begin : g_p1
        logic adv_out;
        assign adv_out      = !vld_pipe[1] || bus.out_ready;
        assign bus.in_ready = adv_out;

        always_comb begin
            hi_a   = '0;
            hi_b   = '0;
            hi_cin = '0;
            for (int i = 0; i < LANES; i++) begin
                hi_a[i]   = bus.in_a[i*LANE_W+H +: H];
                hi_b[i]   = bus.in_b[i*LANE_W+H +: H];
                // half mode: high sub-lane starts fresh with its own carry-in
                hi_cin[i] = bus.in_half ? bus.in_sub : lo_c[i];
            end
        end
        assign hi_lo   = lo_s;
        assign hi_clo  = lo_c;
        assign hi_sub  = bus.in_sub;
        assign hi_half = bus.in_half;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pipe <= '0;
                sum_q    <= '0;
`ifdef SNOWV_MODADD_CARRY_EN
                carry_q  <= '0;
`endif
            end else if (adv_out) begin
                vld_pipe[1] <= bus.in_valid;
                if (bus.in_valid) begin
                    sum_q   <= res_sum;
`ifdef SNOWV_MODADD_CARRY_EN
                    carry_q <= res_carry;
`endif
                end
            end
        end
    end else begin : g_p2
        logic                    s1_en, s2_en;
        logic [LANES-1:0][H-1:0] s1_lo, s1_ahi, s1_bhi;
        logic [LANES-1:0]        s1_clo, s1_cin;
        logic                    s1_sub, s1_half;

        assign s2_en        = !vld_pipe[2] || bus.out_ready;
        assign s1_en        = !vld_pipe[1] || s2_en;
        assign bus.in_ready = s1_en;

        assign hi_a    = s1_ahi;
        assign hi_b    = s1_bhi;
        assign hi_lo   = s1_lo;
        assign hi_clo  = s1_clo;
        assign hi_cin  = s1_cin;
        assign hi_sub  = s1_sub;
        assign hi_half = s1_half;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pipe <= '0;
                sum_q    <= '0;
`ifdef SNOWV_MODADD_CARRY_EN
                carry_q  <= '0;
`endif
                s1_lo    <= '0;
                s1_ahi   <= '0;
                s1_bhi   <= '0;
                s1_clo   <= '0;
                s1_cin   <= '0;
                s1_sub   <= 1'b0;
                s1_half  <= 1'b0;
            end else begin
                if (s2_en) begin
                    vld_pipe[2] <= vld_pipe[1];
                    if (vld_pipe[1]) begin
                        sum_q   <= res_sum;
`ifdef SNOWV_MODADD_CARRY_EN
                        carry_q <= res_carry;
`endif
                    end
                end
                if (s1_en) begin
                    vld_pipe[1] <= bus.in_valid;
                    if (bus.in_valid) begin
                        s1_lo   <= lo_s;
                        s1_clo  <= lo_c;
                        s1_cin  <= bus.in_half ? {LANES{bus.in_sub}} : lo_c;
                        s1_sub  <= bus.in_sub;
                        s1_half <= bus.in_half;
                        for (int i = 0; i < LANES; i++) begin
                            s1_ahi[i] <= bus.in_a[i*LANE_W+H +: H];
                            s1_bhi[i] <= bus.in_b[i*LANE_W+H +: H];
                        end
                    end
                end
            end
        end
    end

    assign bus.out_valid = vld_pipe[PIPE_STAGES];
    assign bus.out_sum   = sum_q;
`ifdef SNOWV_MODADD_CARRY_EN
    assign bus.out_carry = carry_q;
`endif
endmodule

// File: tb/tb_snowv_lane_modadd.sv
`timescale 1ns/1ps
module tb_snowv_lane_modadd;
    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int W      = LANES * LANE_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         sel, vin, ordy, sub, half;
    logic [W-1:0] a, b;
    int           pipe;
    int           n_cmp = 0;
    int           n_err = 0;

    snowv_lane_modadd_if #(.LANES(LANES), .LANE_W(LANE_W)) if1 ();
    snowv_lane_modadd_if #(.LANES(LANES), .LANE_W(LANE_W)) if2 ();

    snowv_lane_modadd #(.LANES(LANES), .LANE_W(LANE_W), .PIPE_STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1));
    snowv_lane_modadd #(.LANES(LANES), .LANE_W(LANE_W), .PIPE_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if2));

    assign if1.in_valid  = vin & ~sel;
    assign if2.in_valid  = vin & sel;
    assign if1.in_a      = a;
    assign if2.in_a      = a;
    assign if1.in_b      = b;
    assign if2.in_b      = b;
    assign if1.in_sub    = sub;
    assign if2.in_sub    = sub;
    assign if1.in_half   = half;
    assign if2.in_half   = half;
    assign if1.out_ready = ordy;
    assign if2.out_ready = ordy;

    wire         m_ready = sel ? if2.in_ready  : if1.in_ready;
    wire         m_valid = sel ? if2.out_valid : if1.out_valid;
    wire [W-1:0] m_sum   = sel ? if2.out_sum   : if1.out_sum;
`ifdef SNOWV_MODADD_CARRY_EN
    wire [2*LANES-1:0] m_carry = sel ? if2.out_carry : if1.out_carry;
`endif

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL P%0d %s: observed %0h expected %0h", pipe, tag, obs, exp);
        end
    endtask

    // single beat: checks latency, result, flags, and hold with X inputs
    task automatic beat(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic th, input logic [W-1:0] es,
                        input logic [2*LANES-1:0] ec);
        @(negedge clk);
        vin = 1'b1; a = ta; b = tb; sub = ts; half = th; ordy = 1'b1;
        for (int k = 1; k <= pipe; k++) begin
            @(negedge clk);
            if (k == 1) begin
                vin = 1'b0; a = 'x; b = 'x; sub = 1'bx; half = 1'bx;
            end
            chk({tag, " valid"}, W'(m_valid), W'(k == pipe));
        end
        chk({tag, " sum"}, m_sum, es);
`ifdef SNOWV_MODADD_CARRY_EN
        chk({tag, " carry"}, W'(m_carry), W'(ec));
`else
        if (ec === 'x) $display("unused flags");
`endif
        @(negedge clk);
        chk({tag, " idle valid"}, W'(m_valid), '0);
        chk({tag, " idle hold"}, m_sum, es);
    endtask

    // 4 back-to-back beats with out_ready=1: latency pipe, one result per cycle
    task automatic stream(input logic [31:0] base);
        logic [31:0] lane;
        logic        ev;
        @(negedge clk);
        ordy = 1'b1;
        for (int c = 0; c < 4 + pipe + 1; c++) begin
            if (c < 4) begin
                lane = base + 32'(c);
                vin = 1'b1; a = {LANES{lane}}; b = {LANES{32'h1}}; sub = 1'b0; half = 1'b0;
            end else begin
                vin = 1'b0; a = 'x; b = 'x;
            end
            #1;
            if (c < 4) chk("stream ready", W'(m_ready), W'(1));
            @(negedge clk);
            ev = (c + 1 >= pipe) && (c + 1 < pipe + 4);
            chk("stream valid", W'(m_valid), W'(ev));
            if (ev) begin
                lane = base + 32'(c + 1 - pipe) + 32'h1;
                chk("stream sum", m_sum, {LANES{lane}});
            end
        end
    endtask

    // 8 beats with out_ready cycling 1,0,0,1
    task automatic backpressure();
        int           tx, rx;
        bit           held, acc;
        logic [W-1:0] hv;
        logic [31:0]  lane;
        tx = 0; rx = 0; held = 0; hv = '0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            @(negedge clk);
            ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (tx < 8) begin
                lane = 32'hA0000000 + 32'(tx);
                vin = 1'b1; a = {LANES{lane}}; b = {LANES{32'(tx)}}; sub = 1'b0; half = 1'b0;
            end else begin
                vin = 1'b0; a = 'x; b = 'x;
            end
            #1;
            acc = vin && m_ready;
            if (held) begin
                chk("bp stall valid", W'(m_valid), W'(1));
                chk("bp stall hold", m_sum, hv);
            end
            if (m_valid) begin
                if (ordy) begin
                    lane = 32'hA0000000 + 32'(2 * rx);
                    chk("bp order", m_sum, {LANES{lane}});
                    rx++;
                    held = 0;
                end else begin
                    held = 1;
                    hv   = m_sum;
                end
            end else begin
                held = 0;
            end
            if (acc) tx++;
        end
        chk("bp count", W'(rx), W'(8));
        vin = 1'b0; a = 'x; b = 'x;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp no extra", W'(m_valid), '0);
        end
    endtask

    // two beats in flight, then a one-cycle reset
    task automatic reset_mid();
        @(negedge clk);
        ordy = 1'b1; vin = 1'b1; a = {LANES{32'h11}}; b = {LANES{32'h22}}; sub = 1'b0; half = 1'b0;
        @(negedge clk);
        a = {LANES{32'h33}};
        @(negedge clk);
        vin = 1'b0; a = 'x; b = 'x; rst = 1'b1;
        chk("rstmid inflight", W'(m_valid), W'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid valid", W'(m_valid), '0);
        chk("rstmid sum", m_sum, '0);
        chk("rstmid ready", W'(m_ready), W'(1));
`ifdef SNOWV_MODADD_CARRY_EN
        chk("rstmid carry", W'(m_carry), '0);
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstmid stale", W'(m_valid), '0);
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; pipe = 1; vin = 1'b0; ordy = 1'b0;
        a = '0; b = '0; sub = 1'b0; half = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset valid1", W'(if1.out_valid), '0);
        chk("reset sum1", if1.out_sum, '0);
        chk("reset ready1", W'(if1.in_ready), W'(1));
        chk("reset valid2", W'(if2.out_valid), '0);
        chk("reset sum2", if2.out_sum, '0);
        chk("reset ready2", W'(if2.in_ready), W'(1));
`ifdef SNOWV_MODADD_CARRY_EN
        chk("reset carry1", W'(if1.out_carry), '0);
        chk("reset carry2", W'(if2.out_carry), '0);
`endif
        for (int p = 1; p <= 2; p++) begin
            pipe = p;
            sel  = (p == 2);
            #1;
            beat("full add",
                 {32'h12345678, 32'h0000FFFF, 32'h7FFFFFFF, 32'hFFFFFFFF},
                 {32'h11111111, 32'h00000001, 32'h00000001, 32'h00000001}, 1'b0, 1'b0,
                 {32'h23456789, 32'h00010000, 32'h80000000, 32'h00000000}, 8'h02);
            beat("half add",
                 {32'h00000000, 32'h00000000, 32'hFFFF0001, 32'h0001FFFF},
                 {32'h00000000, 32'h00000000, 32'h00010001, 32'h00010001}, 1'b0, 1'b1,
                 {32'h00000000, 32'h00000000, 32'h00000002, 32'h00020000}, 8'h09);
            beat("full sub",
                 {32'h00000001, 32'h80000000, 32'h00000005, 32'h00000000},
                 {32'h00000002, 32'h80000000, 32'h00000003, 32'h00000001}, 1'b1, 1'b0,
                 {32'hFFFFFFFF, 32'h00000000, 32'h00000002, 32'hFFFFFFFF}, 8'h82);
            beat("half sub",
                 {32'h00000000, 32'h00000000, 32'h00000000, 32'h00050003},
                 {32'h00000000, 32'h00000000, 32'h00010001, 32'h00010004}, 1'b1, 1'b1,
                 {32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0004FFFF}, 8'h0D);
            stream(32'h0000FFF0 + 32'(p));
            backpressure();
            reset_mid();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
